// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle RV32I main controller sequencing FETCH..WRITEBACK.
// Define ILLEGAL_TRAP_EN to trap unsupported opcodes/branch funct3 in a sticky HALT state.
module mc_control_unit #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [3:0] ALU_control,
  output logic       mem_err,
  output logic       illegal
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [3:0] AluAdd  = 4'b0000;
  localparam logic [3:0] AluSub  = 4'b0001;
  localparam logic [3:0] AluAnd  = 4'b0010;
  localparam logic [3:0] AluOr   = 4'b0011;
  localparam logic [3:0] AluSlt  = 4'b0100;
  localparam logic [3:0] AluSltu = 4'b0101;
  localparam logic [3:0] AluXor  = 4'b0110;
  localparam logic [3:0] AluLui  = 4'b0111;
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSra  = 4'b1001;
  localparam logic [3:0] AluSrl  = 4'b1010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBranch, StJal, StHalt
  } state_e;

`ifdef ILLEGAL_TRAP_EN
  localparam state_e StIllegal = StHalt;
`else
  localparam state_e StIllegal = StFetch;
`endif

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             wait_full;

  // alt selects sub for funct3 000 and sra for funct3 101
  function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    unique case (f3)
      3'b000:  op = alt ? AluSub : AluAdd;
      3'b001:  op = AluSll;
      3'b010:  op = AluSlt;
      3'b011:  op = AluSltu;
      3'b100:  op = AluXor;
      3'b101:  op = alt ? AluSra : AluSrl;
      3'b110:  op = AluOr;
      default: op = AluAnd;
    endcase
    return op;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StFetch;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  assign wait_full = (wait_q == WaitW'(MAX_WAIT));

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    mem_req     = 1'b0;
    MemWrite    = 1'b0;
    AdrSrc      = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    ALU_control = AluAdd;
    mem_err     = 1'b0;
    illegal     = 1'b0;

    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = StDecode;
        end else if (wait_full) begin
          mem_req = 1'b0;
          mem_err = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI, OpLui:      state_d = StExecI;
          OpBr:            state_d = (funct3[2:1] == 2'b01) ? StIllegal : StBranch;
          OpJal:           state_d = StJal;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) begin
          state_d = StMemWb;
        end else if (wait_full) begin
          mem_req = 1'b0;
          mem_err = 1'b1;
          state_d = StFetch;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          state_d = StFetch;
        end else if (wait_full) begin
          mem_req  = 1'b0;
          MemWrite = 1'b0;
          mem_err  = 1'b1;
          state_d  = StFetch;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StExecR: begin
        ALUSrcA     = 2'b10;
        ALU_control = alu_dec(funct3, funct7b5);
        state_d     = StAluWb;
      end
      StExecI: begin
        ALUSrcA     = 2'b10;
        ALUSrcB     = 2'b01;
        // immediate funct3 000 has no sub form; instr[30] only matters for srai
        ALU_control = (opcode == OpLui) ? AluLui :
                      alu_dec(funct3, (funct3 == 3'b101) && funct7b5);
        state_d     = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA = 2'b10;
        state_d = StFetch;
        case (funct3)
          3'b000: begin ALU_control = AluSub;  PCWrite = Z;  end
          3'b001: begin ALU_control = AluSub;  PCWrite = ~Z; end
          3'b100: begin ALU_control = AluSlt;  PCWrite = ~Z; end
          3'b101: begin ALU_control = AluSlt;  PCWrite = Z;  end
          3'b110: begin ALU_control = AluSltu; PCWrite = ~Z; end
          3'b111: begin ALU_control = AluSltu; PCWrite = Z;  end
          default: ;
        endcase
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = StAluWb;
      end
      StHalt: begin
`ifdef ILLEGAL_TRAP_EN
        illegal = 1'b1;
        state_d = StHalt;
`else
        state_d = StFetch;
`endif
      end
      default: state_d = StFetch;
    endcase

    // Outputs go quiet the moment reset asserts, even mid-access.
    if (!reset_n) begin
      mem_req     = 1'b0;
      MemWrite    = 1'b0;
      AdrSrc      = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ResultSrc   = 2'b00;
      ALU_control = AluAdd;
      mem_err     = 1'b0;
      illegal     = 1'b0;
    end
  end

endmodule
